// File: rtl/me_run_ctrl_if.sv
// Request/acknowledge handshake and result bus between the run controller
// and the motion-estimation core.
interface me_run_ctrl_if #(
  parameter int SAD_W  = 16,
  parameter int MVEC_W = 12
);
  logic              req;
  logic              ack;
  logic [SAD_W-1:0]  min_sad;
  logic [MVEC_W-1:0] min_mvec;

  modport master (output req, input ack, min_sad, min_mvec);
  modport slave  (input req, output ack, min_sad, min_mvec);
endinterface

// File: rtl/me_run_ctrl.sv
// Run controller for the motion-estimation core: debounced buttons, 4-phase
// req/ack sequencing, per-run timing with timeout, and a browsable result log.
module me_run_ctrl #(
  parameter logic [15:0] DB_CYCLES = 16'd50000,
  parameter int          SAD_W     = 16,
  parameter int          MVEC_W    = 12,
  parameter int          LOG_DEPTH = 3,
  parameter int          CNT_W     = 24,
  parameter logic [CNT_W-1:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic                 clk,
  input  logic                 RSTN,
  input  logic                 SW_START_N,
  input  logic                 SW_STOP_N,
  input  logic                 SW_NEXT_N,
  input  logic                 cont_mode,
  me_run_ctrl_if.master        core,
  output logic                 busy,
  output logic                 err,
  output logic [SAD_W-1:0]     disp_sad,
  output logic [MVEC_W-1:0]    disp_mvec,
  output logic [CNT_W-1:0]     disp_cycles,
  output logic [LOG_DEPTH-1:0] disp_idx,
  output logic [LOG_DEPTH:0]   disp_count
);

  localparam int              DEPTH    = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] FULL  = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [CNT_W-1:0] TO_LAST = TIMEOUT - CNT_W'(1);
  localparam int              B_START  = 0;
  localparam int              B_STOP   = 1;
  localparam int              B_NEXT   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ACK,
    S_CAPTURE,
    S_WAIT_REL
  } state_t;

  typedef struct packed {
    logic [SAD_W-1:0]  sad;
    logic [MVEC_W-1:0] mvec;
    logic [CNT_W-1:0]  cycles;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Button conditioning: 2-flop synchroniser, stability counter, press pulse
  // ---------------------------------------------------------------------------
  logic [2:0]  btn_raw;
  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [2:0]  db_level;
  logic [2:0]  press;
  logic [15:0] db_cnt [3];

  assign btn_raw = {SW_NEXT_N, SW_STOP_N, SW_START_N};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      sync1    <= '1;
      sync2    <= '1;
      db_level <= '1;
      press    <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_CYCLES - 16'd1) begin
          // Levels differ here, so the old level being 1 means a falling edge.
          db_cnt[i]   <= '0;
          db_level[i] <= sync2[i];
          press[i]    <= db_level[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  logic start_p;
  logic stop_p;
  logic next_p;

  assign start_p = press[B_START];
  assign stop_p  = press[B_STOP];
  assign next_p  = press[B_NEXT];

  // ---------------------------------------------------------------------------
  // Run sequencer
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] run_cnt;
  logic             stop_pend;
  logic             start_run;
  logic             set_req;
  logic             abort;
  logic             capture;
  logic             finish;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    set_req   = 1'b0;
    abort     = 1'b0;
    capture   = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_p) begin
          start_run = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        // Hold off raising req until the core has released ack.
        if (!core.ack) begin
          set_req   = 1'b1;
          state_nxt = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (core.ack) begin
          state_nxt = S_CAPTURE;
        end else if (run_cnt == TO_LAST) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_CAPTURE: begin
        capture   = 1'b1;
        state_nxt = S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (!core.ack) begin
          if (cont_mode && !stop_pend && !stop_p) begin
            state_nxt = S_REQ;
          end else begin
            finish    = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      core.req  <= 1'b0;
      run_cnt   <= '0;
      err       <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      if (set_req)               core.req <= 1'b1;
      else if (capture || abort) core.req <= 1'b0;

      if (start_run || state == S_REQ) run_cnt <= '0;
      else if (state == S_WAIT_ACK)    run_cnt <= run_cnt + CNT_W'(1);

      if (start_run)  err <= 1'b0;
      else if (abort) err <= 1'b1;

      if (start_run || finish || abort) stop_pend <= 1'b0;
      else if (stop_p && busy)          stop_pend <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Result log and browse pointer
  // ---------------------------------------------------------------------------
  entry_t               mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;

  // NOTE: the log storage has no reset; disp_count gates every read, so stale
  // contents are never visible and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= {core.min_sad, core.min_mvec, run_cnt};
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr     <= '0;
      disp_count <= '0;
      disp_idx   <= '0;
    end else if (capture) begin
      // A capture in the same cycle as a browse press takes priority.
      wr_ptr   <= wr_ptr + LOG_DEPTH'(1);
      disp_idx <= wr_ptr;
      if (disp_count != FULL) disp_count <= disp_count + (LOG_DEPTH+1)'(1);
    end else if (next_p && disp_count != '0) begin
      if ({1'b0, disp_idx} == disp_count - (LOG_DEPTH+1)'(1)) disp_idx <= '0;
      else                                                     disp_idx <= disp_idx + LOG_DEPTH'(1);
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      disp_sad    <= '0;
      disp_mvec   <= '0;
      disp_cycles <= '0;
    end else if (disp_count == '0) begin
      disp_sad    <= '0;
      disp_mvec   <= '0;
      disp_cycles <= '0;
    end else begin
      {disp_sad, disp_mvec, disp_cycles} <= mem[disp_idx];
    end
  end

  // Handshake contract: req only rises after ack was low, and is low in IDLE.
  a_req_rise : assert property (@(posedge clk) disable iff (!RSTN)
    $rose(core.req) |-> !$past(core.ack));
  a_idle_req : assert property (@(posedge clk) disable iff (!RSTN)
    (state == S_IDLE) |-> !core.req);

endmodule
